// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider FSM state encoding and ALU control codes.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } div_state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_CMP = 2'b10;

endpackage

// File: rtl/adder.sv
// Parameterised add/subtract unit with zero and carry flags.
// flag[0] = result is zero, flag[1] = carry out (for SUB/CMP: no borrow, i.e. a >= b).
module adder
   import cpu_pkg::*;
#(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   ctrl,
   output logic [W-1:0] result,
   output logic [1:0]   flag
);

   logic [W:0] sum;

   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      case (ctrl)
         ALU_SUB, ALU_CMP: sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
         default:          sum = {1'b0, a} + {1'b0, b};
      endcase
   end

   assign result = sum[W-1:0];
   assign flag   = {sum[W], (sum[W-1:0] == '0)};

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per division.
// Handshake: start is accepted on a rising edge only while ready=1; results are valid while done=1.
module seq_divider
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output div_state_t       dbg_state
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t       state, state_nxt;
   logic [WIDTH-1:0] q_r, rem_r, dsr_r;
   logic [CW-1:0]    cnt_r;
   logic             dz_r;
   logic             accept;
   logic [WIDTH:0]   shifted, diff;
   logic [1:0]       flag;
   logic             ge;
   logic             unused_diff_msb;

   assign shifted = {rem_r, q_r[WIDTH-1]};

   adder #(.W(WIDTH + 1)) u_sub (
      .a      (shifted),
      .b      ({1'b0, dsr_r}),
      .ctrl   (ALU_SUB),
      .result (diff),
      .flag   (flag)
   );

   // A successful subtract always leaves a value below the divisor, so the top bit is zero.
   assign ge              = flag[0] | flag[1];
   assign unused_diff_msb = diff[WIDTH];

   assign ready  = (state == IDLE) || (state == DONE);
   assign accept = start && ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = (divisor == '0) ? DONE : RUN;
            else       state_nxt = IDLE;
         end
         RUN:     if (cnt_r == CW'(1)) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q_r   <= '0;
         rem_r <= '0;
         dsr_r <= '0;
         cnt_r <= '0;
         dz_r  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            dsr_r <= divisor;
            if (divisor == '0) begin
               q_r   <= '1;
               rem_r <= dividend;
               cnt_r <= '0;
               dz_r  <= 1'b1;
            end else begin
               q_r   <= dividend;
               rem_r <= '0;
               cnt_r <= CW'(WIDTH);
               dz_r  <= 1'b0;
            end
         end else if (state == RUN) begin
            cnt_r <= cnt_r - CW'(1);
            q_r   <= {q_r[WIDTH-2:0], ge};
            rem_r <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         end
      end
   end

   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign quotient    = q_r;
   assign remainder   = rem_r;
   assign div_by_zero = dz_r;
   assign dbg_state   = state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// compared against plain integer division.
module tb_seq_divider;
   import cpu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         ready, busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   div_state_t   dbg_state;

   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_pass = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed so far)", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // reference model: plain integer division
   task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) begin
         exp_q.push_back('1);
         exp_q.push_back(a);
      end else begin
         exp_q.push_back(a / b);
         exp_q.push_back(a % b);
      end
   endtask

   // Drive one division; optionally inject a second start at RUN cycle inj_cyc.
   // Returns at #1 after the done edge, i.e. inside the DONE cycle.
   task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_cyc, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input bit check_after);
      int           cyc;
      int           exp_lat;
      logic [W-1:0] eq, er;
      exp_lat = (b == 0) ? 1 : W + 1;
      push_expected(a, b);
      @(negedge clk);
      check({tag, ".ready"}, ready, 1'b1);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      cyc = 1;
      while (!done && cyc < 100) begin
         if (cyc == inj_cyc) begin
            start = 1'b1; dividend = ia; divisor = ib;
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      check({tag, ".latency"}, cyc, exp_lat);
      check({tag, ".done"}, done, 1'b1);
      check({tag, ".quotient"}, quotient, eq);
      check({tag, ".remainder"}, remainder, er);
      check({tag, ".dbz"}, div_by_zero, (b == 0));
      if (check_after) begin
         @(posedge clk); #1;
         check({tag, ".pulse"}, done, 1'b0);
         check({tag, ".idle_ready"}, ready, 1'b1);
         check({tag, ".hold_q"}, quotient, eq);
         check({tag, ".hold_r"}, remainder, er);
      end
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      bit           seen;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.ready", ready, 1'b1);
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.dbz", div_by_zero, 1'b0);
      check("rst.quotient", quotient, 0);
      check("rst.remainder", remainder, 0);
      @(negedge clk);
      rst = 1'b0;

      // directed corner cases
      do_div("d100_7", 100, 7, 0, 0, 0, 1'b1);
      do_div("dmax_1", 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b1);
      do_div("d3_10", 3, 10, 0, 0, 0, 1'b1);
      do_div("d5_0", 5, 0, 0, 0, 0, 1'b1);
      do_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1'b1);
      do_div("d0_5", 0, 5, 0, 0, 0, 1'b1);
      do_div("dmax_2", 32'hFFFF_FFFF, 2, 0, 0, 0, 1'b1);

      // start during RUN is ignored
      do_div("ignore", 50, 5, 10, 9, 2, 1'b1);

      // reset aborts a division in progress
      @(negedge clk);
      start = 1'b1; dividend = 1000; divisor = 3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("abort.busy_before", busy, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort.busy", busy, 1'b0);
      check("abort.ready", ready, 1'b1);
      check("abort.done", done, 1'b0);
      check("abort.quotient", quotient, 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= done;
      end
      check("abort.no_done", seen, 1'b0);
      do_div("after_abort", 20, 6, 0, 0, 0, 1'b1);

      // back-to-back: second start issued in the DONE cycle of the first
      do_div("b2b_first", 40, 3, 0, 0, 0, 1'b0);
      do_div("b2b_second", 7, 7, 0, 0, 0, 1'b1);

      // random operands
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 100)) : $urandom;
         do_div($sformatf("rand%0d", i), ra, rb, 0, 0, 0, ($urandom_range(0, 1) == 1));
      end

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
